// File: rtl/serial_add_seq.sv
// Bit-serial adder sequencer: drives one shared full-adder cell for WIDTH cycles,
// LSB first, then presents the WIDTH-bit sum and the carry-out.
module serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk1,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             fa_x,
  output logic             fa_y,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_c,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB result.
  generate
    if (WIDTH == 1) begin : g_w1
      assign sum_nxt = fa_sum;
    end else begin : g_wn
      assign sum_nxt = {fa_sum, sum_sh[WIDTH-1:1]};
    end
  endgenerate

  // busy is a flop that is high exactly in RUN, so the cell inputs come from registers only.
  assign fa_x   = busy & a_sh[0];
  assign fa_y   = busy & b_sh[0];
  assign fa_cin = busy & carry;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          sum_sh <= sum_nxt;
          carry  <= fa_c;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            sum   <= sum_nxt;
            cout  <= fa_c;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_seq.sv
// Bench for serial_add_seq: behavioural full-adder cell, vector table, scoreboard
// on done, plus hand sequences for ignored start, held start, reset abort, WIDTH=1.
module tb_serial_add_seq;
  logic       clk1 = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       cin = 1'b0;
  logic       fa_x, fa_y, fa_cin, fa_sum, fa_c, busy, done, cout;
  logic [7:0] sum;

  logic       start1 = 1'b0, cin1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0, sum1;
  logic       fa_x1, fa_y1, fa_cin1, fa_sum1, fa_c1, busy1, done1, cout1;

  int checks = 0;
  int failures = 0;
  logic [8:0] exp_q[$];

  always #5 clk1 = ~clk1;

  assign fa_sum  = fa_x ^ fa_y ^ fa_cin;
  assign fa_c    = (fa_x & fa_y) | (fa_x & fa_cin) | (fa_y & fa_cin);
  assign fa_sum1 = fa_x1 ^ fa_y1 ^ fa_cin1;
  assign fa_c1   = (fa_x1 & fa_y1) | (fa_x1 & fa_cin1) | (fa_y1 & fa_cin1);

  serial_add_seq #(.WIDTH(8)) u8 (
    .clk1(clk1), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .fa_x(fa_x), .fa_y(fa_y), .fa_cin(fa_cin), .fa_sum(fa_sum), .fa_c(fa_c),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_add_seq #(.WIDTH(1)) u1 (
    .clk1(clk1), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .fa_x(fa_x1), .fa_y(fa_y1), .fa_cin(fa_cin1), .fa_sum(fa_sum1), .fa_c(fa_c1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every done must match the oldest outstanding expected {cout,sum}.
  always @(negedge clk1) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        chk("sb_sum", {24'd0, sum}, {24'd0, e[7:0]});
        chk("sb_cout", {31'd0, cout}, {31'd0, e[8]});
      end
    end
  end

  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                        input logic [7:0] es, input logic ec, input int poke);
    int bcnt;
    bit seen;
    @(negedge clk1);
    a = ta; b = tb; cin = tc; start = 1'b1;
    exp_q.push_back({ec, es});
    @(negedge clk1);
    start = 1'b0;
    bcnt = 0;
    seen = 0;
    for (int k = 1; k <= 30 && !seen; k++) begin
      if (k > 1) @(negedge clk1);
      if (k == poke) begin
        start = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b1;
      end else if (k == poke + 1) begin
        start = 1'b0;
      end
      if (busy) bcnt++;
      if (done) begin
        seen = 1;
        chk("latency", k, 9);
        chk("fa_idle_in_done", {29'd0, fa_x, fa_y, fa_cin}, 32'd0);
        chk("busy_in_done", {31'd0, busy}, 32'd0);
      end
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
    chk("busy_width", bcnt, 8);
  endtask

  typedef struct {
    logic [7:0] a, b;
    logic       cin;
    logic [7:0] s;
    logic       co;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int k;
    bit seen;
    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    vecs[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
    vecs[7] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};

    repeat (2) @(negedge clk1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sum", {24'd0, sum}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    chk("rst_fa", {29'd0, fa_x, fa_y, fa_cin}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk1);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].co, -1);

    // Start re-asserted 3 cycles into RUN must be ignored.
    run_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 3);
    @(negedge clk1);
    chk("no_extra_op", {31'd0, busy}, 32'd0);

    // Start held high: back-to-back operations, done pulses 10 cycles apart.
    @(negedge clk1);
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    exp_q.push_back({1'b0, 8'h02});
    seen = 0;
    for (k = 1; k <= 30 && !seen; k++) begin
      @(negedge clk1);
      if (done) seen = 1;
    end
    chk("held_first_latency", k - 1, 9);
    a = 8'h10; b = 8'h20;
    exp_q.push_back({1'b0, 8'h30});
    seen = 0;
    for (k = 1; k <= 30 && !seen; k++) begin
      @(negedge clk1);
      if (k == 5) chk("sum_held_in_run", {24'd0, sum}, 32'h02);
      if (done) seen = 1;
    end
    start = 1'b0;
    chk("held_spacing", k - 1, 10);

    // Asynchronous reset in the middle of RUN.
    repeat (2) @(negedge clk1);
    a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
    @(negedge clk1);
    start = 1'b0;
    repeat (3) @(negedge clk1);
    chk("pre_abort_busy", {31'd0, busy}, 32'd1);
    chk("pre_abort_fa", {29'd0, fa_x, fa_y, fa_cin}, 32'd7);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_sum", {24'd0, sum}, 32'd0);
    chk("abort_cout", {31'd0, cout}, 32'd0);
    chk("abort_fa", {29'd0, fa_x, fa_y, fa_cin}, 32'd0);
    @(negedge clk1);
    rst_n = 1'b1;
    run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, -1);

    // WIDTH=1 instance.
    @(negedge clk1);
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
    @(negedge clk1);
    start1 = 1'b0;
    chk("w1_busy", {30'd0, busy1, done1}, 32'd2);
    chk("w1_fa", {29'd0, fa_x1, fa_y1, fa_cin1}, 32'd7);
    @(negedge clk1);
    chk("w1_done", {30'd0, busy1, done1}, 32'd1);
    chk("w1_result", {30'd0, cout1, sum1}, 32'd3);
    @(negedge clk1);
    chk("w1_idle", {30'd0, busy1, done1}, 32'd0);

    repeat (3) @(negedge clk1);
    chk("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
